// File: rtl/spi_slave_rx_pkg.sv
// Shared definitions for the SPI receive slave: frame width, FSM states and
// the layout of a received PWM configuration frame.
package spi_slave_rx_pkg;

  localparam int unsigned SPI_DATA_WIDTH = 16;

  // Field positions of a configuration frame (duty in the high byte).
  localparam int unsigned DUTY_MSB = 15;
  localparam int unsigned DUTY_LSB = 8;
  localparam int unsigned FREQ_MSB = 7;
  localparam int unsigned FREQ_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Received frame as seen by the PWM config FIFO consumer.
  typedef struct packed {
    logic [DUTY_MSB-DUTY_LSB:0] duty;
    logic [FREQ_MSB-FREQ_LSB:0] freq;
  } cfg_frame_t;

endpackage

// File: rtl/spi_slave_rx_sync_bit.sv
// One-bit multi-flop synchroniser with a configurable reset level.
// Ports: clk, rst (sync, active-low), d (async input), q (synchronised output).
module spi_slave_rx_sync_bit #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Reset loads the pin's idle level so no false edge appears after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive slave. Oversamples SCLK/CS_N/MOSI in the clk domain,
// deserialises MSB-first frames into the PWM config FIFO and returns a
// status word on MISO.
// Ports:
//   clk, rst (sync, active-low)
//   i_sclk, i_cs_n, i_mosi      SPI pins from the master (async)
//   o_miso                      serial status to the master
//   i_tx_status                 status word, captured at frame start
//   o_rx_data, o_rx_data_valid  FIFO write data / write enable
//   i_fifo_full                 FIFO full flag
//   o_overrun, o_frame_err      sticky error flags, cleared by i_clr_err
module spi_slave_rx
  import spi_slave_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_sclk,
  input  logic                  i_cs_n,
  input  logic                  i_mosi,
  output logic                  o_miso,
  input  logic [DATA_WIDTH-1:0] i_tx_status,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_data_valid,
  input  logic                  i_fifo_full,
  output logic                  o_overrun,
  output logic                  o_frame_err,
  input  logic                  i_clr_err
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  logic sclk_s, cs_s, mosi_s;
  logic sclk_d, cs_d;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic last_rise, frame_abort, overrun_set;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      bitcnt;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] tx_shift;

  spi_slave_rx_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk (clk), .rst (rst), .d (i_sclk), .q (sclk_s)
  );

  spi_slave_rx_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
    .clk (clk), .rst (rst), .d (i_cs_n), .q (cs_s)
  );

  spi_slave_rx_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk (clk), .rst (rst), .d (i_mosi), .q (mosi_s)
  );

  // Edge detection against one extra delayed copy.
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  assign last_rise   = (state == ST_ACTIVE) && sclk_rise &&
                       (bitcnt == CNT_W'(DATA_WIDTH - 1));
  assign overrun_set = (state == ST_DONE) && i_fifo_full;

  // MISO is the top of the transmit shift register, so it is a flop output.
  assign o_miso = tx_shift[DATA_WIDTH-1];

  // Next-state logic; a completing frame takes priority over CS_N release.
  always_comb begin
    state_nxt   = state;
    frame_abort = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_fall) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (last_rise) begin
          state_nxt = ST_DONE;
        end else if (cs_rise) begin
          state_nxt   = ST_IDLE;
          frame_abort = (bitcnt != '0);
        end
      end
      ST_DONE: begin
        state_nxt = cs_s ? ST_IDLE : ST_ACTIVE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register, shift datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= ST_IDLE;
      sclk_d          <= 1'b0;
      cs_d            <= 1'b1;
      bitcnt          <= '0;
      rx_shift        <= '0;
      tx_shift        <= '0;
      o_rx_data       <= '0;
      o_rx_data_valid <= 1'b0;
      o_overrun       <= 1'b0;
      o_frame_err     <= 1'b0;
    end else begin
      state           <= state_nxt;
      sclk_d          <= sclk_s;
      cs_d            <= cs_s;
      o_rx_data_valid <= 1'b0;

      // A new error wins over a simultaneous clear.
      if (overrun_set)    o_overrun <= 1'b1;
      else if (i_clr_err) o_overrun <= 1'b0;

      if (frame_abort)    o_frame_err <= 1'b1;
      else if (i_clr_err) o_frame_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            tx_shift <= i_tx_status;
            bitcnt   <= '0;
          end
        end
        ST_ACTIVE: begin
          if (sclk_rise) begin
            rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
            bitcnt   <= bitcnt + CNT_W'(1);
          end
          // The fall that trails a frame boundary must not consume the
          // freshly loaded MSB, so only shift once a bit has been clocked.
          if (sclk_fall && (bitcnt != '0)) begin
            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
          end
        end
        ST_DONE: begin
          if (!i_fifo_full) begin
            o_rx_data       <= rx_shift;
            o_rx_data_valid <= 1'b1;
          end
          bitcnt   <= '0;
          tx_shift <= i_tx_status;
        end
        default: bitcnt <= '0;
      endcase
    end
  end

endmodule
